// File: rtl/acq_pkg.sv
// Shared types and constants for the triggered acquisition controller.
package acq_pkg;

    localparam int unsigned STATE_WIDTH = 3;

    typedef enum logic [STATE_WIDTH-1:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } acq_state_e;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    // States in which accepted samples belong to the running acquisition.
    function automatic logic is_acquiring(input acq_state_e s);
        return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/acq_trigger_detect.sv
// Level-crossing edge detector; remembers the previous accepted sample of the
// current acquisition and flags a crossing on the incoming one.
module acq_trigger_detect
    import acq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  sample_en,
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] level,
    input  logic                  edge_sel,
    output logic                  edge_hit_c
);

    logic [DATA_WIDTH-1:0] prev;
    logic                  prev_valid;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clear) begin
            prev_valid <= 1'b0;
        end else if (sample_en) begin
            prev       <= sample;
            prev_valid <= 1'b1;
        end
    end

    // No crossing can be seen until one sample of this acquisition is held.
    always_comb begin
        edge_hit_c = 1'b0;
        if (prev_valid) begin
            if (edge_sel == EDGE_FALLING) begin
                edge_hit_c = (prev > level) && (sample <= level);
            end else begin
                edge_hit_c = (prev < level) && (sample >= level);
            end
        end
    end

endmodule

// File: rtl/acq_controller.sv
// Pre/post-trigger acquisition controller: streams accepted ADC samples into a
// circular buffer and stops a programmable number of samples after a trigger.
module acq_controller
    import acq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DF_WIDTH   = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  adc_data_i,
    input  logic                   adc_rdy_i,
    output logic                   adc_ack_o,
    output logic [DF_WIDTH-1:0]    decimation_factor_o,
    input  logic                   cfg_start_i,
    input  logic                   cfg_stop_i,
    input  logic                   cfg_force_i,
    input  logic [DF_WIDTH-1:0]    cfg_df_i,
    input  logic [CNT_WIDTH-1:0]   cfg_pretrig_i,
    input  logic [CNT_WIDTH-1:0]   cfg_total_i,
    input  logic [DATA_WIDTH-1:0]  cfg_level_i,
    input  logic                   cfg_edge_i,
    output logic                   buf_wr_o,
    output logic [CNT_WIDTH-1:0]   buf_addr_o,
    output logic [DATA_WIDTH-1:0]  buf_data_o,
    output logic [CNT_WIDTH-1:0]   trig_addr_o,
    output logic [STATE_WIDTH-1:0] state_o,
    output logic                   triggered_o,
    output logic                   done_o
);

    acq_state_e            state;
    logic [CNT_WIDTH-1:0]  pretrig_q;
    logic [CNT_WIDTH-1:0]  post_target_q;
    logic [DATA_WIDTH-1:0] level_q;
    logic                  edge_q;
    logic                  force_q;
    logic [CNT_WIDTH-1:0]  wptr;
    logic [CNT_WIDTH-1:0]  pre_cnt;
    logic [CNT_WIDTH-1:0]  post_cnt;

    logic                  accept_c;
    logic                  start_fire_c;
    logic                  write_en_c;
    logic                  edge_hit_c;
    logic                  trig_fire_c;
    logic [CNT_WIDTH-1:0]  pre_cnt_nxt_c;
    logic [CNT_WIDTH-1:0]  post_cnt_nxt_c;
    logic [CNT_WIDTH-1:0]  post_target_c;

    assign adc_ack_o = adc_rdy_i;
    assign state_o   = state;

    // Command decode; stop outranks start, trigger and the sample write.
    always_comb begin
        accept_c       = adc_rdy_i & adc_ack_o;
        start_fire_c   = cfg_start_i & ~cfg_stop_i & ((state == ST_IDLE) || (state == ST_DONE));
        write_en_c     = accept_c & ~cfg_stop_i & is_acquiring(state);
        trig_fire_c    = write_en_c & (state == ST_ARMED) & (edge_hit_c | force_q | cfg_force_i);
        pre_cnt_nxt_c  = pre_cnt + CNT_WIDTH'(1);
        post_cnt_nxt_c = post_cnt + CNT_WIDTH'(1);
        post_target_c  = CNT_WIDTH'(1);
        if (cfg_total_i > cfg_pretrig_i) begin
            post_target_c = cfg_total_i - cfg_pretrig_i;
        end
    end

    acq_trigger_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_trigger_detect (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .clear      (start_fire_c),
        .sample_en  (write_en_c),
        .sample     (adc_data_i),
        .level      (level_q),
        .edge_sel   (edge_q),
        .edge_hit_c (edge_hit_c)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            pretrig_q           <= '0;
            post_target_q       <= '0;
            level_q             <= '0;
            edge_q              <= EDGE_RISING;
            force_q             <= 1'b0;
            wptr                <= '0;
            pre_cnt             <= '0;
            post_cnt            <= '0;
            decimation_factor_o <= '0;
            buf_wr_o            <= 1'b0;
            buf_addr_o          <= '0;
            buf_data_o          <= '0;
            trig_addr_o         <= '0;
            triggered_o         <= 1'b0;
            done_o              <= 1'b0;
        end else begin
            buf_wr_o <= 1'b0;
            if (cfg_stop_i) begin
                state   <= ST_IDLE;
                force_q <= 1'b0;
                done_o  <= 1'b0;
            end else if (start_fire_c) begin
                pretrig_q           <= cfg_pretrig_i;
                post_target_q       <= post_target_c;
                level_q             <= cfg_level_i;
                edge_q              <= cfg_edge_i;
                decimation_factor_o <= cfg_df_i;
                force_q             <= 1'b0;
                wptr                <= '0;
                pre_cnt             <= '0;
                post_cnt            <= '0;
                triggered_o         <= 1'b0;
                done_o              <= 1'b0;
                state               <= (cfg_pretrig_i == '0) ? ST_ARMED : ST_PRE;
            end else begin
                // A force with no sample this cycle is held for the next one.
                if ((state == ST_ARMED) && cfg_force_i && !trig_fire_c) begin
                    force_q <= 1'b1;
                end
                if (write_en_c) begin
                    buf_wr_o   <= 1'b1;
                    buf_addr_o <= wptr;
                    buf_data_o <= adc_data_i;
                    wptr       <= wptr + CNT_WIDTH'(1);
                    case (state)
                        ST_PRE: begin
                            pre_cnt <= pre_cnt_nxt_c;
                            if (pre_cnt_nxt_c == pretrig_q) begin
                                state <= ST_ARMED;
                            end
                        end
                        ST_ARMED: begin
                            if (trig_fire_c) begin
                                trig_addr_o <= wptr;
                                triggered_o <= 1'b1;
                                force_q     <= 1'b0;
                                post_cnt    <= CNT_WIDTH'(1);
                                // The trigger sample is post sample one; a target of one is already met.
                                if (post_target_q == CNT_WIDTH'(1)) begin
                                    state  <= ST_DONE;
                                    done_o <= 1'b1;
                                end else begin
                                    state  <= ST_POST;
                                end
                            end
                        end
                        ST_POST: begin
                            post_cnt <= post_cnt_nxt_c;
                            if (post_cnt_nxt_c == post_target_q) begin
                                state  <= ST_DONE;
                                done_o <= 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

endmodule
